// File: rtl/ln_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ln_pkg: shared types, tag constants and width helper for the LN divider   |
// | arbiter slice.                                                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ln_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  localparam logic REQ_EX  = 1'b0;
  localparam logic REQ_EX2 = 1'b1;

  function automatic int dout_w(input int dvd_w, input int dsr_w);
    return dvd_w + dsr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ln_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ln_tag_fifo: in-order FIFO of 1-bit requester tags for in-flight divisions |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ln_tag_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        push_tag_i,
  input  logic        pop_i,
  output logic        head_tag_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_tag_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_tag_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ln_div_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ln_div_arbiter: round-robin share of one AXI-Stream divider between the    |
// | E[x] and E[x^2] requesters. Optional stats: LN_DIV_ARB_STATS_EN.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ln_div_arbiter
  import ln_pkg::*;
#(
  parameter int DVD_W   = 12,
  parameter int DSR_W   = 8,
  parameter int DOUT_W  = dout_w(DVD_W, DSR_W),
  parameter int MAX_OUT = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DVD_W-1:0]  i_req0_dividend,
  input  logic [DSR_W-1:0]  i_req0_divisor,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DVD_W-1:0]  i_req1_dividend,
  input  logic [DSR_W-1:0]  i_req1_divisor,
  output logic              o_div_dvd_tvalid,
  input  logic              i_div_dvd_tready,
  output logic [DVD_W-1:0]  o_div_dvd_tdata,
  output logic              o_div_dsr_tvalid,
  input  logic              i_div_dsr_tready,
  output logic [DSR_W-1:0]  o_div_dsr_tdata,
  input  logic              i_div_dout_tvalid,
  output logic              o_div_dout_tready,
  input  logic [DOUT_W-1:0] i_div_dout_tdata,
  output logic              o_rsp0_valid,
  output logic              o_rsp1_valid,
  output logic [DOUT_W-1:0] o_rsp_data,
  output logic              o_busy,
  output logic              o_err
`ifdef LN_DIV_ARB_STATS_EN
  ,
  output logic [15:0]               o_grant0_cnt,
  output logic [15:0]               o_grant1_cnt,
  output logic [$clog2(MAX_OUT):0]  o_max_inflight
`endif
);

  arb_state_e               state_q;
  logic                     ptr_q;
  logic                     tag_q;
  logic                     dvd_done_q;
  logic                     dsr_done_q;
  logic [DVD_W-1:0]         dvd_q;
  logic [DSR_W-1:0]         dsr_q;
  logic                     rsp0_q;
  logic                     rsp1_q;
  logic [DOUT_W-1:0]        rsp_data_q;
  logic                     err_q;

  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     head_tag;
  logic [$clog2(MAX_OUT):0] fifo_count;
  logic                     grant_en;
  logic                     win;
  logic                     dvd_hs;
  logic                     dsr_hs;
  logic                     issue_done;
  logic                     pop;

  assign grant_en = (state_q == IDLE) && (i_req0_valid || i_req1_valid) && !fifo_full;
  // With a single requester it wins outright; the pointer only breaks ties.
  assign win      = (i_req0_valid && i_req1_valid) ? ptr_q : i_req1_valid;

  assign o_req0_ready      = grant_en && (win == REQ_EX);
  assign o_req1_ready      = grant_en && (win == REQ_EX2);
  assign o_div_dvd_tvalid  = (state_q == ISSUE) && !dvd_done_q;
  assign o_div_dsr_tvalid  = (state_q == ISSUE) && !dsr_done_q;
  assign o_div_dvd_tdata   = dvd_q;
  assign o_div_dsr_tdata   = dsr_q;
  assign o_div_dout_tready = 1'b1;

  assign dvd_hs     = o_div_dvd_tvalid && i_div_dvd_tready;
  assign dsr_hs     = o_div_dsr_tvalid && i_div_dsr_tready;
  assign issue_done = (state_q == ISSUE) && (dvd_done_q || dvd_hs) && (dsr_done_q || dsr_hs);
  assign pop        = i_div_dout_tvalid && !fifo_empty;

  assign o_rsp0_valid = rsp0_q;
  assign o_rsp1_valid = rsp1_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_err        = err_q;
  assign o_busy       = (state_q == ISSUE) || !fifo_empty;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      tag_q      <= 1'b0;
      dvd_done_q <= 1'b0;
      dsr_done_q <= 1'b0;
      dvd_q      <= '0;
      dsr_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            dvd_q   <= win ? i_req1_dividend : i_req0_dividend;
            dsr_q   <= win ? i_req1_divisor  : i_req0_divisor;
            tag_q   <= win;
            ptr_q   <= ~win;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_done) begin
            dvd_done_q <= 1'b0;
            dsr_done_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            if (dvd_hs) dvd_done_q <= 1'b1;
            if (dsr_hs) dsr_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rsp0_q <= pop && (head_tag == REQ_EX);
      rsp1_q <= pop && (head_tag == REQ_EX2);
      if (pop) rsp_data_q <= i_div_dout_tdata;
      if (i_div_dout_tvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  ln_tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk_i      (i_clk),
    .rst_ni     (i_rstn),
    .push_i     (issue_done),
    .push_tag_i (tag_q),
    .pop_i      (pop),
    .head_tag_o (head_tag),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

`ifdef LN_DIV_ARB_STATS_EN
  logic [15:0]              grant0_cnt_q;
  logic [15:0]              grant1_cnt_q;
  logic [$clog2(MAX_OUT):0] max_inflight_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      grant0_cnt_q   <= '0;
      grant1_cnt_q   <= '0;
      max_inflight_q <= '0;
    end else begin
      if (i_req0_valid && o_req0_ready && (grant0_cnt_q != 16'hFFFF)) grant0_cnt_q <= grant0_cnt_q + 16'd1;
      if (i_req1_valid && o_req1_ready && (grant1_cnt_q != 16'hFFFF)) grant1_cnt_q <= grant1_cnt_q + 16'd1;
      if (fifo_count > max_inflight_q) max_inflight_q <= fifo_count;
    end
  end

  assign o_grant0_cnt   = grant0_cnt_q;
  assign o_grant1_cnt   = grant1_cnt_q;
  assign o_max_inflight = max_inflight_q;
`else
  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ln_div_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ln_div_arbiter: directed self-checking bench for ln_div_arbiter.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ln_div_arbiter;

  localparam int DVD_W  = 12;
  localparam int DSR_W  = 8;
  localparam int DOUT_W = 20;

  logic              i_clk = 1'b0;
  logic              i_rstn;
  logic              i_req0_valid, i_req1_valid;
  logic              o_req0_ready, o_req1_ready;
  logic [DVD_W-1:0]  i_req0_dividend, i_req1_dividend;
  logic [DSR_W-1:0]  i_req0_divisor, i_req1_divisor;
  logic              o_div_dvd_tvalid, i_div_dvd_tready;
  logic [DVD_W-1:0]  o_div_dvd_tdata;
  logic              o_div_dsr_tvalid, i_div_dsr_tready;
  logic [DSR_W-1:0]  o_div_dsr_tdata;
  logic              i_div_dout_tvalid, o_div_dout_tready;
  logic [DOUT_W-1:0] i_div_dout_tdata;
  logic              o_rsp0_valid, o_rsp1_valid;
  logic [DOUT_W-1:0] o_rsp_data;
  logic              o_busy, o_err;

  int checks = 0;
  int passed = 0;

  always #5 i_clk = ~i_clk;

  ln_div_arbiter dut (
    .i_clk             (i_clk),
    .i_rstn            (i_rstn),
    .i_req0_valid      (i_req0_valid),
    .o_req0_ready      (o_req0_ready),
    .i_req0_dividend   (i_req0_dividend),
    .i_req0_divisor    (i_req0_divisor),
    .i_req1_valid      (i_req1_valid),
    .o_req1_ready      (o_req1_ready),
    .i_req1_dividend   (i_req1_dividend),
    .i_req1_divisor    (i_req1_divisor),
    .o_div_dvd_tvalid  (o_div_dvd_tvalid),
    .i_div_dvd_tready  (i_div_dvd_tready),
    .o_div_dvd_tdata   (o_div_dvd_tdata),
    .o_div_dsr_tvalid  (o_div_dsr_tvalid),
    .i_div_dsr_tready  (i_div_dsr_tready),
    .o_div_dsr_tdata   (o_div_dsr_tdata),
    .i_div_dout_tvalid (i_div_dout_tvalid),
    .o_div_dout_tready (o_div_dout_tready),
    .i_div_dout_tdata  (i_div_dout_tdata),
    .o_rsp0_valid      (o_rsp0_valid),
    .o_rsp1_valid      (o_rsp1_valid),
    .o_rsp_data        (o_rsp_data),
    .o_busy            (o_busy),
    .o_err             (o_err)
  );

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req0_valid      = 1'b0;
    i_req1_valid      = 1'b0;
    i_req0_dividend   = '0;
    i_req1_dividend   = '0;
    i_req0_divisor    = '0;
    i_req1_divisor    = '0;
    i_div_dvd_tready  = 1'b1;
    i_div_dsr_tready  = 1'b1;
    i_div_dout_tvalid = 1'b0;
    i_div_dout_tdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rstn = 1'b0;
    cyc();
    cyc();
    i_rstn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rstn = 1'b0;
    #1;
    checks++; if ({o_req0_ready, o_req1_ready, o_div_dvd_tvalid, o_div_dsr_tvalid, o_rsp0_valid, o_rsp1_valid, o_busy, o_err} !== 8'h00)
      $display("FAIL reset_ctrl: got %b want 00000000", {o_req0_ready, o_req1_ready, o_div_dvd_tvalid, o_div_dsr_tvalid, o_rsp0_valid, o_rsp1_valid, o_busy, o_err}); else passed++;
    checks++; if (o_div_dout_tready !== 1'b1) $display("FAIL reset_dout_tready: got %b want 1", o_div_dout_tready); else passed++;
    checks++; if ({o_div_dvd_tdata, o_div_dsr_tdata, o_rsp_data} !== 40'h0) $display("FAIL reset_data: got %h want 0", {o_div_dvd_tdata, o_div_dsr_tdata, o_rsp_data}); else passed++;
    cyc();
    i_rstn = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    i_req0_valid = 1'b1; i_req0_dividend = 12'hFD8; i_req0_divisor = 8'd8;
    #1;
    checks++; if ({o_req0_ready, o_req1_ready} !== 2'b10) $display("FAIL single_ready: got %b want 10", {o_req0_ready, o_req1_ready}); else passed++;
    cyc();
    i_req0_valid = 1'b0;
    #1;
    checks++; if ({o_div_dvd_tvalid, o_div_dsr_tvalid, o_req0_ready} !== 3'b110) $display("FAIL single_issue_valid: got %b want 110", {o_div_dvd_tvalid, o_div_dsr_tvalid, o_req0_ready}); else passed++;
    checks++; if (o_div_dvd_tdata !== 12'hFD8) $display("FAIL single_dvd: got %h want fd8", o_div_dvd_tdata); else passed++;
    checks++; if (o_div_dsr_tdata !== 8'd8) $display("FAIL single_dsr: got %h want 08", o_div_dsr_tdata); else passed++;
    cyc();
    #1;
    checks++; if ({o_div_dvd_tvalid, o_div_dsr_tvalid, o_busy} !== 3'b001) $display("FAIL single_after_issue: got %b want 001", {o_div_dvd_tvalid, o_div_dsr_tvalid, o_busy}); else passed++;
    cyc();
    cyc();
    i_div_dout_tvalid = 1'b1; i_div_dout_tdata = 20'hABCDE;
    #1;
    checks++; if (o_rsp0_valid !== 1'b0) $display("FAIL single_rsp_early: got %b want 0", o_rsp0_valid); else passed++;
    cyc();
    i_div_dout_tvalid = 1'b0;
    #1;
    checks++; if ({o_rsp0_valid, o_rsp1_valid, o_busy} !== 3'b100) $display("FAIL single_rsp: got %b want 100", {o_rsp0_valid, o_rsp1_valid, o_busy}); else passed++;
    checks++; if (o_rsp_data !== 20'hABCDE) $display("FAIL single_rsp_data: got %h want abcde", o_rsp_data); else passed++;
    cyc();
    #1;
    checks++; if (o_rsp0_valid !== 1'b0) $display("FAIL single_rsp_pulse: got %b want 0", o_rsp0_valid); else passed++;
  endtask

  task automatic test_round_robin();
    logic exp_w;
    logic [DVD_W-1:0] exp_d;
    do_reset();
    i_req0_valid = 1'b1; i_req0_dividend = 12'd100; i_req0_divisor = 8'd3;
    i_req1_valid = 1'b1; i_req1_dividend = 12'hFF9; i_req1_divisor = 8'd5;
    for (int k = 0; k < 8; k++) begin
      exp_w = k[0];
      exp_d = exp_w ? 12'hFF9 : 12'd100;
      i_div_dout_tvalid = 1'b0;
      #1;
      checks++; if ({o_req1_ready, o_req0_ready} !== (exp_w ? 2'b10 : 2'b01)) $display("FAIL rr_grant%0d: got %b want w=%0d", k, {o_req1_ready, o_req0_ready}, exp_w); else passed++;
      if (k >= 2) begin
        checks++; if ({o_rsp1_valid, o_rsp0_valid, o_rsp_data} !== {k[0], ~k[0], 20'(k - 2)})
          $display("FAIL rr_rsp%0d: got r1=%b r0=%b d=%h", k - 2, o_rsp1_valid, o_rsp0_valid, o_rsp_data); else passed++;
      end
      cyc();
      if (k > 0) begin
        i_div_dout_tvalid = 1'b1; i_div_dout_tdata = 20'(k - 1);
      end
      #1;
      checks++; if ({o_req0_ready, o_req1_ready, o_div_dvd_tdata} !== {2'b00, exp_d}) $display("FAIL rr_issue%0d: got rdy=%b d=%h want 00 %h", k, {o_req0_ready, o_req1_ready}, o_div_dvd_tdata, exp_d); else passed++;
      cyc();
    end
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    i_div_dout_tvalid = 1'b1; i_div_dout_tdata = 20'd7;
    #1;
    checks++; if ({o_rsp1_valid, o_rsp0_valid, o_rsp_data} !== {2'b01, 20'd6}) $display("FAIL rr_rsp6: got r1=%b r0=%b d=%h", o_rsp1_valid, o_rsp0_valid, o_rsp_data); else passed++;
    cyc();
    i_div_dout_tvalid = 1'b0;
    #1;
    checks++; if ({o_rsp1_valid, o_rsp0_valid, o_rsp_data, o_busy} !== {2'b10, 20'd7, 1'b0}) $display("FAIL rr_rsp7: got r1=%b r0=%b d=%h busy=%b", o_rsp1_valid, o_rsp0_valid, o_rsp_data, o_busy); else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    i_req0_valid = 1'b1; i_req0_dividend = 12'd55; i_req0_divisor = 8'd9;
    i_div_dsr_tready = 1'b0;
    #1;
    checks++; if (o_req0_ready !== 1'b1) $display("FAIL bp_grant: got %b want 1", o_req0_ready); else passed++;
    cyc();
    i_req0_valid = 1'b0;
    #1;
    checks++; if ({o_div_dvd_tvalid, o_div_dsr_tvalid} !== 2'b11) $display("FAIL bp_c1: got %b want 11", {o_div_dvd_tvalid, o_div_dsr_tvalid}); else passed++;
    for (int c = 2; c <= 3; c++) begin
      cyc();
      #1;
      checks++; if ({o_div_dvd_tvalid, o_div_dsr_tvalid, o_div_dsr_tdata, o_busy} !== {2'b01, 8'd9, 1'b1})
        $display("FAIL bp_c%0d: got dvd=%b dsr=%b d=%h busy=%b want 0 1 09 1", c, o_div_dvd_tvalid, o_div_dsr_tvalid, o_div_dsr_tdata, o_busy); else passed++;
    end
    cyc();
    i_div_dsr_tready = 1'b1;
    i_req0_valid = 1'b1;
    #1;
    checks++; if ({o_div_dsr_tvalid, o_req0_ready} !== 2'b10) $display("FAIL bp_c4: got %b want 10", {o_div_dsr_tvalid, o_req0_ready}); else passed++;
    cyc();
    i_req0_valid = 1'b0;
    i_div_dout_tvalid = 1'b1; i_div_dout_tdata = 20'h00007;
    #1;
    checks++; if ({o_div_dsr_tvalid, o_busy} !== 2'b01) $display("FAIL bp_pushed: got %b want 01", {o_div_dsr_tvalid, o_busy}); else passed++;
    cyc();
    i_div_dout_tvalid = 1'b0;
    #1;
    checks++; if ({o_rsp0_valid, o_busy, o_err} !== 3'b100) $display("FAIL bp_rsp: got %b want 100", {o_rsp0_valid, o_busy, o_err}); else passed++;
  endtask

  task automatic test_fifo_full();
    do_reset();
    i_req0_valid = 1'b1; i_req0_dividend = 12'd1; i_req0_divisor = 8'd1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (o_req0_ready !== 1'b1) $display("FAIL full_grant%0d: got %b want 1", k, o_req0_ready); else passed++;
      cyc();
      cyc();
    end
    #1;
    checks++; if (o_req0_ready !== 1'b0) $display("FAIL full_block0: got %b want 0", o_req0_ready); else passed++;
    cyc();
    i_div_dout_tvalid = 1'b1; i_div_dout_tdata = 20'd5;
    #1;
    checks++; if (o_req0_ready !== 1'b0) $display("FAIL full_block1: got %b want 0", o_req0_ready); else passed++;
    cyc();
    i_div_dout_tvalid = 1'b0;
    #1;
    checks++; if ({o_req0_ready, o_rsp0_valid} !== 2'b11) $display("FAIL full_regrant: got %b want 11", {o_req0_ready, o_rsp0_valid}); else passed++;
    cyc();
    i_req0_valid = 1'b0;
  endtask

  task automatic test_push_pop_same();
    do_reset();
    i_req0_valid = 1'b1; i_req0_dividend = 12'd10; i_req0_divisor = 8'd2;
    cyc();
    i_req0_valid = 1'b0;
    cyc();
    i_req1_valid = 1'b1; i_req1_dividend = 12'd20; i_req1_divisor = 8'd4;
    #1;
    checks++; if ({o_req1_ready, o_req0_ready} !== 2'b10) $display("FAIL pp_grant1: got %b want 10", {o_req1_ready, o_req0_ready}); else passed++;
    cyc();
    i_req1_valid = 1'b0;
    i_div_dout_tvalid = 1'b1; i_div_dout_tdata = 20'h11111;
    cyc();
    i_div_dout_tdata = 20'h22222;
    #1;
    checks++; if ({o_rsp0_valid, o_rsp1_valid, o_rsp_data, o_busy} !== {2'b10, 20'h11111, 1'b1}) $display("FAIL pp_rsp0: got r0=%b r1=%b d=%h busy=%b", o_rsp0_valid, o_rsp1_valid, o_rsp_data, o_busy); else passed++;
    cyc();
    i_div_dout_tvalid = 1'b0;
    #1;
    checks++; if ({o_rsp0_valid, o_rsp1_valid, o_rsp_data, o_busy, o_err} !== {2'b01, 20'h22222, 2'b00}) $display("FAIL pp_rsp1: got r0=%b r1=%b d=%h busy=%b err=%b", o_rsp0_valid, o_rsp1_valid, o_rsp_data, o_busy, o_err); else passed++;
  endtask

  task automatic test_err();
    do_reset();
    i_div_dout_tvalid = 1'b1; i_div_dout_tdata = 20'd3;
    #1;
    checks++; if (o_err !== 1'b0) $display("FAIL err_before: got %b want 0", o_err); else passed++;
    cyc();
    i_div_dout_tvalid = 1'b0;
    #1;
    checks++; if ({o_err, o_rsp0_valid, o_rsp1_valid, o_busy, o_rsp_data} !== {4'b1000, 20'd0}) $display("FAIL err_set: got err=%b r0=%b r1=%b busy=%b d=%h", o_err, o_rsp0_valid, o_rsp1_valid, o_busy, o_rsp_data); else passed++;
    cyc();
    cyc();
    #1;
    checks++; if (o_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", o_err); else passed++;
    i_rstn = 1'b0;
    #1;
    checks++; if (o_err !== 1'b0) $display("FAIL err_clear: got %b want 0", o_err); else passed++;
    cyc();
    i_rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fifo_full();
    test_push_pop_same();
    test_err();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ln_div_arbiter.md
Name: ln_div_arbiter

Overview:
- Shares one divider-generator instance (separate AXI-Stream dividend, divisor and dout channels) between two mean-computing requesters.
  - Requester 0 is the E[x] accumulator.
  - Requester 1 is the E[x²] accumulator.
- Arbitrates round-robin and holds each operand pair stable until both divider input channels accept it.
- Tags every issued operation in an in-order tag FIFO and routes each divider result back to its owner as a one-cycle pulse.
- Sits between the LayerNorm statistic units and the single shared divider.

Parameters:
- DVD_W, 12, dividend width in bits (9 + clog2(N) for N=8).
- DSR_W, 8, divisor width in bits (the IP-rounded divisor port width).
- DOUT_W, 20, divider dout tdata width; must equal DVD_W+DSR_W.
- MAX_OUT, 4, maximum number of in-flight divisions (tag FIFO depth); must be a power of 2 and at least 2.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_req0_valid  in  1  requester 0 has an operand pair
- o_req0_ready  out  1  requester 0 operand pair accepted this cycle
- i_req0_dividend  in  DVD_W  signed dividend
- i_req0_divisor  in  DSR_W  unsigned divisor
- i_req1_valid, o_req1_ready, i_req1_dividend, i_req1_divisor: same as requester 0
- o_div_dvd_tvalid  out  1  divider dividend channel valid
- i_div_dvd_tready  in  1  divider dividend channel ready
- o_div_dvd_tdata  out  DVD_W  dividend to divider
- o_div_dsr_tvalid  out  1  divider divisor channel valid
- i_div_dsr_tready  in  1  divider divisor channel ready
- o_div_dsr_tdata  out  DSR_W  divisor to divider
- i_div_dout_tvalid  in  1  divider result valid
- o_div_dout_tready  out  1  result ready; tied to 1
- i_div_dout_tdata  in  DOUT_W  raw divider result, forwarded unchanged
- o_rsp0_valid  out  1  one-cycle result pulse for requester 0
- o_rsp1_valid  out  1  one-cycle result pulse for requester 1
- o_rsp_data  out  DOUT_W  registered result; the requester extracts the quotient
- o_busy  out  1  high in ISSUE or when the tag FIFO is non-empty
- o_err  out  1  sticky flag: a result arrived with the tag FIFO empty

Behaviour:
- Reset (async, i_rstn=0) forces:
  - state=IDLE, round-robin pointer=0 (requester 0 preferred), tag FIFO empty, both channel-done flags 0;
  - all outputs 0 except o_div_dout_tready=1.
- Reset mid-operation drops all in-flight tags. Any divider result arriving after reset release therefore sets o_err. Integration must reset the divider together with this block.
- IDLE state:
  - If any i_reqX_valid is high and tag count < MAX_OUT, the winner is chosen combinationally.
    - If only one requester is valid, it wins.
    - If both are valid, the requester indicated by the pointer wins.
  - In the same cycle: o_reqW_ready=1, the dividend, divisor and tag W are latched into hold registers, and the pointer is set to the non-winner. Next state is ISSUE.
  - When the FIFO is full, no ready is asserted and the state stays IDLE.
  - o_reqX_ready is high only in IDLE and only for the winner, so at most one ready is high per cycle.
- ISSUE state:
  - o_div_dvd_tvalid = !dvd_done and o_div_dsr_tvalid = !dsr_done; tdata outputs come from the hold registers.
  - A channel's done flag sets on its own valid&ready. The two channels may complete in different cycles.
  - When both channels have completed (including both in the same cycle), push the tag, clear both flags and go to IDLE.
  - Maximum issue rate is 1 operation per 2 cycles.
- Result path:
  - On i_div_dout_tvalid, pop the head tag.
  - Next cycle: o_rsp_data = the latched tdata, and o_rspT_valid=1 for exactly 1 cycle. Latency is 1 cycle.
  - A push and a pop in the same cycle leaves the count unchanged. The count never exceeds MAX_OUT.
  - If tvalid arrives with the FIFO empty: no pop, no response pulse, o_err set until reset.
- Widths: the tag is 1 bit. The FIFO pointers are clog2(MAX_OUT) bits and wrap modulo MAX_OUT. The count is clog2(MAX_OUT)+1 bits.

Optional Feature:
- Macro: LN_DIV_ARB_STATS_EN.
- When defined, the block adds these outputs:
  - o_grant0_cnt and o_grant1_cnt, 16 bits each, saturating. Each increments on its own requester's accepted handshake.
  - o_max_inflight, clog2(MAX_OUT)+1 bits. High-water mark of the tag count.
  - All three reset to 0.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- The shared package ln_pkg holds:
  - the state encoding (IDLE=1'b0, ISSUE=1'b1);
  - the tag constants REQ_EX=1'b0 and REQ_EX2=1'b1;
  - the DOUT_W derivation function.
- One natural sub-module is ln_tag_fifo: a synchronous FIFO of 1-bit entries, MAX_OUT deep, with push, pop, full, empty and count. It is instantiated once.

Test Plan:
- Only req0 valid (dividend 12'sd-40, divisor 8); both treadies held high; dout returned 3 cycles later → o_req0_ready pulses once; the divider sees -40 and 8; o_rsp0_valid pulses 1 cycle after dout; o_rsp_data equals the dout.
- req0 and req1 held valid continuously for 8 grants → grants alternate 0,1,0,1 starting at 0; results returned in order are routed 0,1,0,1.
- i_div_dsr_tready held low for 3 cycles while dvd_tready=1 → dvd_tvalid drops after 1 cycle; dsr_tvalid stays high with stable data; the operation is pushed only once the divisor is accepted.
- MAX_OUT=4 with no dout returned → after 4 issues, no ready is asserted; returning one dout re-enables one grant on the next IDLE cycle.
- Same cycle: a tag push (ISSUE completion) and a dout pop → the count is unchanged and the correct requester is routed.
- dout tvalid with the FIFO empty → o_err=1, no rsp pulse; o_err stays 1 until i_rstn=0 clears it.
